// File: rtl/s386_resp_misr_if.sv
// Handshake/bus bundle between the s386 response compactor and its controller.
// Optional MISR_XMASK_EN adds the per-bit unknown-output mask.
interface s386_resp_misr_if #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [WIDTH-1:0] golden;
`ifdef MISR_XMASK_EN
    logic [WIDTH-1:0] xmask;
`endif
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [LEN_W-1:0] count;

    modport master (
`ifdef MISR_XMASK_EN
        output xmask,
`endif
        output start, len, din, din_valid, golden,
        input  busy, done, pass, signature, count
    );

    modport slave (
`ifdef MISR_XMASK_EN
        input  xmask,
`endif
        input  start, len, din, din_valid, golden,
        output busy, done, pass, signature, count
    );
endinterface

// File: rtl/s386_resp_misr.sv
// Galois-form MISR compacting the 7 s386 primary outputs over a programmed beat count.
// Define MISR_XMASK_EN to add the xmask input that zeroes unknown din bits.
module s386_resp_misr #(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] POLY  = 7'h03,
    parameter logic [WIDTH-1:0] SEED  = 7'h01,
    parameter int unsigned      LEN_W = 16
) (
    input  logic                CK,
    input  logic                RST,
    s386_resp_misr_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] din_m;
    logic [WIDTH-1:0] sig_upd;
    logic             last_beat;

`ifdef MISR_XMASK_EN
    assign din_m = bus.din & ~bus.xmask;
`else
    assign din_m = bus.din;
`endif

    assign sig_upd   = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din_m;
    assign last_beat = (count_q == (len_q - LEN_W'(1)));

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        len_d   = len_q;
        pass_d  = pass_q;
        done_d  = done_q;
        busy_d  = busy_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    sig_d   = SEED;
                    count_d = '0;
                    if (bus.len == '0) begin
                        // Zero-length session completes immediately on the seed.
                        pass_d  = (SEED == bus.golden);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        len_d   = bus.len;
                        pass_d  = 1'b0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.din_valid) begin
                    sig_d   = sig_upd;
                    count_d = count_q + LEN_W'(1);
                    if (last_beat) begin
                        pass_d  = (sig_upd == bus.golden);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            len_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            len_q   <= len_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
    assign bus.count     = count_q;
endmodule
